// File: rtl/ext_int_ctrl_if.sv
// Interrupt handshake between the external interrupt controller and the
// CSR/trap logic. The controller is the master (it produces the request);
// the CSR array is the slave (it supplies enables and pipeline state).
interface ext_int_ctrl_if;
  logic       csr_meie;
  logic       csr_rmie;
  logic       stall;
  logic       int_block;
  logic       cmd_mret_ex;
  logic       g_interrupt;
  logic       g_interrupt_1shot;
  logic [1:0] g_interrupt_priv;
  logic       int_pending;
  logic [7:0] int_lost_cnt;

  modport master (
    input  csr_meie, csr_rmie, stall, int_block, cmd_mret_ex,
    output g_interrupt, g_interrupt_1shot, g_interrupt_priv,
           int_pending, int_lost_cnt
  );

  modport slave (
    output csr_meie, csr_rmie, stall, int_block, cmd_mret_ex,
    input  g_interrupt, g_interrupt_1shot, g_interrupt_priv,
           int_pending, int_lost_cnt
  );
endinterface

// File: rtl/ext_int_ctrl.sv
// Machine-mode external interrupt controller. Synchronizes the external
// request pin, latches it (edge or level), gates it with the CSR enables and
// pipeline state, and holds the handler active until mret, followed by a
// short holdoff window before another interrupt can be taken.
module ext_int_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 1,
  parameter int HOLDOFF     = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          int_req_pin,
  ext_int_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACTIVE = 2'b01,
    ST_HOLD   = 2'b10
  } state_e;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLDOFF - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   req_s;
  logic                   pending_r;
  logic                   pending_nxt_s;
  logic [7:0]             lost_cnt_r;
  logic [7:0]             lost_nxt_s;
  state_e                 state_r;
  state_e                 state_nxt_s;
  logic [3:0]             cnt_r;
  logic [3:0]             cnt_nxt_s;
  logic                   take_s;
  logic                   g_int_r;
  logic                   shot_r;

  // Synchronizer chain for the asynchronous request pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], int_req_pin};
    end
  end

  assign req_s = sync_r[SYNC_STAGES-1];

  // Only IDLE may take; the handler must be out of HOLD first.
  assign take_s = (state_r == ST_IDLE) & pending_r & bus.csr_meie &
                  bus.csr_rmie & ~bus.stall & ~bus.int_block;

  generate
    if (EDGE_MODE != 0) begin : g_edge
      logic req_d_r;
      logic rise_s;

      // Delayed copy of the synchronized request for rising-edge detection.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          req_d_r <= 1'b0;
        end else begin
          req_d_r <= req_s;
        end
      end

      assign rise_s = req_s & ~req_d_r;

      // Pending latch (a new edge beats the take-clear) and lost-edge counter.
      always_comb begin
        pending_nxt_s = pending_r;
        lost_nxt_s    = lost_cnt_r;
        if (rise_s) begin
          pending_nxt_s = 1'b1;
        end else if (take_s) begin
          pending_nxt_s = 1'b0;
        end else begin
          pending_nxt_s = pending_r;
        end
        if (rise_s & pending_r & ~take_s & (lost_cnt_r != 8'hFF)) begin
          lost_nxt_s = lost_cnt_r + 8'd1;
        end else begin
          lost_nxt_s = lost_cnt_r;
        end
      end
    end else begin : g_level
      // Level mode: pending simply follows the synchronized pin.
      always_comb begin
        pending_nxt_s = req_s;
        lost_nxt_s    = 8'd0;
      end
    end
  endgenerate

  // Pending and lost-edge registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r  <= 1'b0;
      lost_cnt_r <= 8'd0;
    end else begin
      pending_r  <= pending_nxt_s;
      lost_cnt_r <= lost_nxt_s;
    end
  end

  // Handler state machine: next state and holdoff counter.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (take_s) begin
          state_nxt_s = ST_ACTIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACTIVE: begin
        if (bus.cmd_mret_ex & ~bus.stall) begin
          state_nxt_s = ST_HOLD;
          cnt_nxt_s   = HOLD_LOAD;
        end else begin
          state_nxt_s = ST_ACTIVE;
        end
      end
      ST_HOLD: begin
        if (cnt_r == 4'd0) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Registered handler-active level and one-cycle entry strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_int_r <= 1'b0;
      shot_r  <= 1'b0;
    end else begin
      g_int_r <= (state_nxt_s == ST_ACTIVE);
      shot_r  <= take_s;
    end
  end

  assign bus.g_interrupt       = g_int_r;
  assign bus.g_interrupt_1shot = shot_r;
  assign bus.g_interrupt_priv  = 2'b11;
  assign bus.int_pending       = pending_r;
  assign bus.int_lost_cnt      = lost_cnt_r;

endmodule

// File: tb/tb_ext_int_ctrl.sv
// Directed testbench for ext_int_ctrl: one edge-mode and one level-mode
// instance, each scenario in its own task with inline expected values.
module tb_ext_int_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pin_e = 1'b0;
  logic pin_l = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  ext_int_ctrl_if ie ();
  ext_int_ctrl_if il ();

  ext_int_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(1), .HOLDOFF(4)) dut_e (
    .clk(clk), .rst_n(rst_n), .int_req_pin(pin_e), .bus(ie)
  );
  ext_int_ctrl #(.SYNC_STAGES(2), .EDGE_MODE(0), .HOLDOFF(4)) dut_l (
    .clk(clk), .rst_n(rst_n), .int_req_pin(pin_l), .bus(il)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pin pulse; returns four cycles after the pulse started.
  task automatic pulse_e();
    pin_e = 1'b1;
    tick();
    pin_e = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    ie.csr_meie = 1'b1; ie.csr_rmie = 1'b1; ie.stall = 1'b0;
    ie.int_block = 1'b0; ie.cmd_mret_ex = 1'b0;
    il.csr_meie = 1'b1; il.csr_rmie = 1'b1; il.stall = 1'b0;
    il.int_block = 1'b0; il.cmd_mret_ex = 1'b0;
    #2;
    n_checks++; if (ie.g_interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_gint got %b exp 0", ie.g_interrupt); end
    n_checks++; if (ie.g_interrupt_1shot !== 1'b0) begin n_fail++; $display("FAIL reset_1shot got %b exp 0", ie.g_interrupt_1shot); end
    n_checks++; if (ie.int_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b exp 0", ie.int_pending); end
    n_checks++; if (ie.int_lost_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_lost got %0d exp 0", ie.int_lost_cnt); end
    n_checks++; if (ie.g_interrupt_priv !== 2'b11) begin n_fail++; $display("FAIL reset_priv got %b exp 11", ie.g_interrupt_priv); end
    n_checks++; if (il.g_interrupt !== 1'b0) begin n_fail++; $display("FAIL reset_gint_lvl got %b exp 0", il.g_interrupt); end
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_edge_basic();
    pin_e = 1'b1;
    tick();                                   // t0+1
    pin_e = 1'b0;
    tick();                                   // t0+2
    n_checks++; if (ie.int_pending !== 1'b0) begin n_fail++; $display("FAIL eb_pend_early got %b exp 0", ie.int_pending); end
    tick();                                   // t0+3
    n_checks++; if (ie.int_pending !== 1'b1) begin n_fail++; $display("FAIL eb_pend_t3 got %b exp 1", ie.int_pending); end
    n_checks++; if (ie.g_interrupt_1shot !== 1'b0) begin n_fail++; $display("FAIL eb_1shot_t3 got %b exp 0", ie.g_interrupt_1shot); end
    tick();                                   // t0+4
    n_checks++; if (ie.g_interrupt_1shot !== 1'b1) begin n_fail++; $display("FAIL eb_1shot_t4 got %b exp 1", ie.g_interrupt_1shot); end
    n_checks++; if (ie.g_interrupt !== 1'b1) begin n_fail++; $display("FAIL eb_gint_t4 got %b exp 1", ie.g_interrupt); end
    n_checks++; if (ie.int_pending !== 1'b0) begin n_fail++; $display("FAIL eb_pend_clr got %b exp 0", ie.int_pending); end
    tick();                                   // t0+5
    n_checks++; if (ie.g_interrupt_1shot !== 1'b0) begin n_fail++; $display("FAIL eb_1shot_t5 got %b exp 0", ie.g_interrupt_1shot); end
    n_checks++; if (ie.g_interrupt !== 1'b1) begin n_fail++; $display("FAIL eb_gint_t5 got %b exp 1", ie.g_interrupt); end
    // mret held off by stall, then accepted
    ie.stall = 1'b1; ie.cmd_mret_ex = 1'b1;
    tick();
    n_checks++; if (ie.g_interrupt !== 1'b1) begin n_fail++; $display("FAIL eb_mret_stalled got %b exp 1", ie.g_interrupt); end
    ie.stall = 1'b0;
    tick();
    ie.cmd_mret_ex = 1'b0;
    for (int i = 0; i < 5; i++) begin
      n_checks++; if (ie.g_interrupt !== 1'b0 || ie.g_interrupt_1shot !== 1'b0) begin n_fail++; $display("FAIL eb_hold_%0d got gint=%b shot=%b exp 0 0", i, ie.g_interrupt, ie.g_interrupt_1shot); end
      tick();
    end
  endtask

  task automatic test_gating();
    ie.csr_rmie = 1'b0;
    pulse_e();
    n_checks++; if (ie.int_pending !== 1'b1) begin n_fail++; $display("FAIL gt_pend got %b exp 1", ie.int_pending); end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (ie.g_interrupt_1shot !== 1'b0) begin n_fail++; $display("FAIL gt_rmie_%0d got %b exp 0", i, ie.g_interrupt_1shot); end
    end
    ie.csr_rmie = 1'b1; ie.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (ie.g_interrupt_1shot !== 1'b0) begin n_fail++; $display("FAIL gt_stall_%0d got %b exp 0", i, ie.g_interrupt_1shot); end
    end
    ie.stall = 1'b0; ie.int_block = 1'b1;
    tick();
    n_checks++; if (ie.g_interrupt_1shot !== 1'b0) begin n_fail++; $display("FAIL gt_block got %b exp 0", ie.g_interrupt_1shot); end
    ie.int_block = 1'b0;
    tick();
    n_checks++; if (ie.g_interrupt_1shot !== 1'b1) begin n_fail++; $display("FAIL gt_take got %b exp 1", ie.g_interrupt_1shot); end
    // enables dropping while active do not end the handler
    ie.csr_meie = 1'b0; ie.csr_rmie = 1'b0;
    tick();
    n_checks++; if (ie.g_interrupt_1shot !== 1'b0) begin n_fail++; $display("FAIL gt_no_repeat got %b exp 0", ie.g_interrupt_1shot); end
    n_checks++; if (ie.g_interrupt !== 1'b1) begin n_fail++; $display("FAIL gt_active_hold got %b exp 1", ie.g_interrupt); end
    ie.csr_meie = 1'b1; ie.csr_rmie = 1'b1;
    ie.cmd_mret_ex = 1'b1; tick(); ie.cmd_mret_ex = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_lost_edges();
    ie.csr_meie = 1'b0;
    repeat (3) pulse_e();
    n_checks++; if (ie.int_pending !== 1'b1) begin n_fail++; $display("FAIL le_pend got %b exp 1", ie.int_pending); end
    n_checks++; if (ie.int_lost_cnt !== 8'd2) begin n_fail++; $display("FAIL le_cnt2 got %0d exp 2", ie.int_lost_cnt); end
    repeat (260) pulse_e();
    n_checks++; if (ie.int_lost_cnt !== 8'd255) begin n_fail++; $display("FAIL le_sat got %0d exp 255", ie.int_lost_cnt); end
    ie.csr_meie = 1'b1;
    tick();
    n_checks++; if (ie.g_interrupt_1shot !== 1'b1) begin n_fail++; $display("FAIL le_take got %b exp 1", ie.g_interrupt_1shot); end
    n_checks++; if (ie.int_pending !== 1'b0) begin n_fail++; $display("FAIL le_pend_clr got %b exp 0", ie.int_pending); end
    ie.cmd_mret_ex = 1'b1; tick(); ie.cmd_mret_ex = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_reentry();
    pulse_e();
    n_checks++; if (ie.g_interrupt_1shot !== 1'b1) begin n_fail++; $display("FAIL re_first got %b exp 1", ie.g_interrupt_1shot); end
    pulse_e();
    n_checks++; if (ie.int_pending !== 1'b1) begin n_fail++; $display("FAIL re_pend got %b exp 1", ie.int_pending); end
    n_checks++; if (ie.g_interrupt_1shot !== 1'b0) begin n_fail++; $display("FAIL re_no_take got %b exp 0", ie.g_interrupt_1shot); end
    n_checks++; if (ie.int_lost_cnt !== 8'd255) begin n_fail++; $display("FAIL re_lost got %0d exp 255", ie.int_lost_cnt); end
    ie.cmd_mret_ex = 1'b1;
    tick();                                   // M+1: HOLD
    ie.cmd_mret_ex = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      n_checks++; if (ie.g_interrupt !== 1'b0 || ie.g_interrupt_1shot !== 1'b0) begin n_fail++; $display("FAIL re_hold_%0d got gint=%b shot=%b exp 0 0", i, ie.g_interrupt, ie.g_interrupt_1shot); end
      tick();
    end
    n_checks++; if (ie.g_interrupt_1shot !== 1'b1) begin n_fail++; $display("FAIL re_second got %b exp 1", ie.g_interrupt_1shot); end
    n_checks++; if (ie.g_interrupt !== 1'b1) begin n_fail++; $display("FAIL re_gint got %b exp 1", ie.g_interrupt); end
    ie.cmd_mret_ex = 1'b1; tick(); ie.cmd_mret_ex = 1'b0;
    repeat (5) tick();
  endtask

  task automatic test_level();
    pin_l = 1'b1;
    repeat (4) tick();
    n_checks++; if (il.g_interrupt_1shot !== 1'b1) begin n_fail++; $display("FAIL lv_first got %b exp 1", il.g_interrupt_1shot); end
    n_checks++; if (il.int_lost_cnt !== 8'd0) begin n_fail++; $display("FAIL lv_lost got %0d exp 0", il.int_lost_cnt); end
    tick();
    il.cmd_mret_ex = 1'b1; tick(); il.cmd_mret_ex = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      n_checks++; if (il.g_interrupt !== 1'b0) begin n_fail++; $display("FAIL lv_hold_%0d got %b exp 0", i, il.g_interrupt); end
      tick();
    end
    n_checks++; if (il.g_interrupt_1shot !== 1'b1) begin n_fail++; $display("FAIL lv_retake got %b exp 1", il.g_interrupt_1shot); end
    pin_l = 1'b0;
    repeat (5) tick();
    n_checks++; if (il.int_pending !== 1'b0) begin n_fail++; $display("FAIL lv_pend_low got %b exp 0", il.int_pending); end
    il.cmd_mret_ex = 1'b1; tick(); il.cmd_mret_ex = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++; if (il.g_interrupt !== 1'b0 || il.g_interrupt_1shot !== 1'b0 || il.int_pending !== 1'b0) begin n_fail++; $display("FAIL lv_idle_%0d got gint=%b shot=%b pend=%b exp 0 0 0", i, il.g_interrupt, il.g_interrupt_1shot, il.int_pending); end
    end
  endtask

  task automatic test_async_reset();
    pulse_e();
    tick();
    n_checks++; if (ie.g_interrupt !== 1'b1) begin n_fail++; $display("FAIL ar_active got %b exp 1", ie.g_interrupt); end
    #3;
    rst_n = 1'b0;
    #1;
    n_checks++; if (ie.g_interrupt !== 1'b0) begin n_fail++; $display("FAIL ar_gint got %b exp 0", ie.g_interrupt); end
    n_checks++; if (ie.int_lost_cnt !== 8'd0) begin n_fail++; $display("FAIL ar_lost got %0d exp 0", ie.int_lost_cnt); end
    n_checks++; if (ie.g_interrupt_priv !== 2'b11) begin n_fail++; $display("FAIL ar_priv got %b exp 11", ie.g_interrupt_priv); end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_checks++; if (ie.g_interrupt !== 1'b0 || ie.g_interrupt_1shot !== 1'b0 || ie.int_pending !== 1'b0) begin n_fail++; $display("FAIL ar_quiet_%0d got gint=%b shot=%b pend=%b exp 0 0 0", i, ie.g_interrupt, ie.g_interrupt_1shot, ie.int_pending); end
    end
  endtask

  initial begin
    test_reset();
    test_edge_basic();
    test_gating();
    test_lost_edges();
    test_reentry();
    test_level();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
